uart_mem_access_ctrl: RTL and testbench

- Sequences the debug load/readback port shared by the instruction and data memories.
- Assembles UART command bytes into one memory access frame, then stalls the CPU, pulses the memory request, collects the 42-bit response and serializes it back as UART bytes.
- Sits between the UART byte receiver/transmitter and the two memories' write_mem_req / target_* / rw_flag port.

---
 rtl/uart_mem_access_ctrl_pkg.sv | 46 ++++
 rtl/uart_mem_access_ctrl_if.sv | 28 ++
 rtl/uart_tx_serializer.sv | 58 +++++
 rtl/uart_mem_access_ctrl.sv | 245 ++++++++++++++++++++++++
 tb/tb_uart_mem_access_ctrl.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_mem_access_ctrl_pkg.sv
// Shared definitions for the UART debug memory-access controller.
// Holds the controller state encoding, command-byte bit positions, memory
// selector codes, response/shift widths, default ACK/NACK codes and a helper
// that tells whether the controller is in the phase where incoming bytes
// must be dropped.
package uart_mem_access_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ADDR = 3'd1,
        DATA = 3'd2,
        HALT = 3'd3,
        REQ  = 3'd4,
        WAIT = 3'd5,
        ACK  = 3'd6,
        TX   = 3'd7
    } state_t;

    // Command byte 0 layout: {rw, mem_type, 5'b0, addr[8]}
    localparam int CMD_RW_BIT    = 7;
    localparam int CMD_MEM_BIT   = 6;
    localparam int CMD_ADDR8_BIT = 0;

    localparam logic MEM_INSTR = 1'b1;
    localparam logic MEM_DATA  = 1'b0;

    localparam int RESP_W  = 42;
    localparam int SHIFT_W = 48;
    // Wide enough for the largest wait the controller ever counts
    localparam int CNT_W   = 17;

    localparam logic [7:0] DEF_ACK_BYTE  = 8'hAC;
    localparam logic [7:0] DEF_NACK_BYTE = 8'hEE;

    // True from HALT through TX: the frame is committed, rx bytes are dropped
    // and the CPU is held off.
    function automatic logic rx_locked(input state_t st);
        logic locked;
        case (st)
            HALT, REQ, WAIT, ACK, TX: locked = 1'b1;
            default:                  locked = 1'b0;
        endcase
        return locked;
    endfunction

endpackage

// File: rtl/uart_mem_access_ctrl_if.sv
// Debug load/readback port shared by the instruction and data memories.
// master (controller): drives write_mem_req, target_mem_type, target_addr,
//                      rw_flag, wdata; receives both memories' rdata/ready.
// slave  (memories)  : the mirror image.
interface uart_mem_access_ctrl_if;
    import uart_mem_access_ctrl_pkg::*;

    logic              write_mem_req;
    logic              target_mem_type;
    logic [8:0]        target_addr;
    logic              rw_flag;
    logic [31:0]       wdata;
    logic [RESP_W-1:0] instr_rdata;
    logic              instr_ready;
    logic [RESP_W-1:0] data_rdata;
    logic              data_ready;

    modport master (
        output write_mem_req, target_mem_type, target_addr, rw_flag, wdata,
        input  instr_rdata, instr_ready, data_rdata, data_ready
    );

    modport slave (
        input  write_mem_req, target_mem_type, target_addr, rw_flag, wdata,
        output instr_rdata, instr_ready, data_rdata, data_ready
    );

endinterface

// File: rtl/uart_tx_serializer.sv
// Byte serializer for the response path: a 48-bit shift register presenting
// its top byte on tx_data, a pending-byte counter and the valid/ready
// handshake toward the UART transmitter.
// Ports:
//   clk, reset  - clock, asynchronous active-high reset
//   load        - one-cycle strobe: take load_data/load_count
//   load_data   - bytes to send, first byte in [47:40]
//   load_count  - number of bytes pending (1..6)
//   tx_ready    - transmitter accepts the current byte
//   tx_valid    - tx_data valid, held until accepted
//   tx_data     - current byte
//   done        - the last pending byte is being accepted this cycle
module uart_tx_serializer
    import uart_mem_access_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic [SHIFT_W-1:0] load_data,
    input  logic [2:0]         load_count,
    input  logic               tx_ready,
    output logic               tx_valid,
    output logic [7:0]         tx_data,
    output logic               done
);

    logic [SHIFT_W-1:0] shreg_r;
    logic [2:0]         count_r;
    logic               tx_valid_r;
    logic               accept_s;

    // Handshake decode
    always_comb begin
        accept_s = tx_valid_r && tx_ready;
        done     = accept_s && (count_r == 3'd1);
    end

    // Shift register, pending count and valid flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shreg_r    <= {SHIFT_W{1'b0}};
            count_r    <= 3'd0;
            tx_valid_r <= 1'b0;
        end else if (load) begin
            shreg_r    <= load_data;
            count_r    <= load_count;
            tx_valid_r <= (load_count != 3'd0);
        end else if (accept_s) begin
            shreg_r    <= {shreg_r[SHIFT_W-9:0], 8'h00};
            count_r    <= count_r - 3'd1;
            tx_valid_r <= (count_r != 3'd1);
        end
    end

    assign tx_valid = tx_valid_r;
    assign tx_data  = shreg_r[SHIFT_W-1 -: 8];

endmodule

// File: rtl/uart_mem_access_ctrl.sv
// UART debug memory-access controller.
// Assembles UART command bytes into a memory access frame, halts the CPU,
// pulses the memory request, collects the read response (or times out) and
// serializes the result back as UART bytes.
// Ports:
//   clk, reset   - clock, asynchronous active-high reset
//   rx_valid/rx_data          - received byte strobe and value
//   tx_valid/tx_data/tx_ready - response byte handshake
//   cpu_enable   - low while an access is in progress
//   rx_overrun   - sticky: a byte arrived while the frame was busy
//   busy         - high outside IDLE
//   mem          - memory debug port (master side)
// Build option: define FRAME_TIMEOUT_EN to abandon a partial frame after
// FRAME_TIMEOUT idle cycles in ADDR/DATA; otherwise a partial frame waits
// indefinitely.
module uart_mem_access_ctrl
    import uart_mem_access_ctrl_pkg::*;
#(
    parameter int         HALT_CYCLES   = 4,
    parameter int         RESP_TIMEOUT  = 16,
    parameter logic [7:0] ACK_BYTE      = DEF_ACK_BYTE,
    parameter logic [7:0] NACK_BYTE     = DEF_NACK_BYTE
`ifdef FRAME_TIMEOUT_EN
    ,
    parameter int         FRAME_TIMEOUT = 100000
`endif
)
(
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          rx_valid,
    input  logic [7:0]                    rx_data,
    output logic                          tx_valid,
    output logic [7:0]                    tx_data,
    input  logic                          tx_ready,
    output logic                          cpu_enable,
    output logic                          rx_overrun,
    output logic                          busy,
    uart_mem_access_ctrl_if.master        mem
);

    state_t             state_r, state_nxt_s;
    logic [CNT_W-1:0]   cnt_r, cnt_nxt_s;
    logic [1:0]         byte_cnt_r;
    logic               cpu_enable_r, busy_r, write_mem_req_r, rx_overrun_r;
    logic               target_mem_type_r, rw_flag_r;
    logic [8:0]         target_addr_r;
    logic [31:0]        wdata_r;
    logic               resp_ready_s;
    logic [RESP_W-1:0]  resp_data_s;
    logic               ser_load_s, ser_done_s;
    logic [SHIFT_W-1:0] ser_data_s;
    logic [2:0]         ser_count_s;

    // Only the memory that was addressed may answer
    always_comb begin
        if (target_mem_type_r == MEM_INSTR) begin
            resp_ready_s = mem.instr_ready;
            resp_data_s  = mem.instr_rdata;
        end else begin
            resp_ready_s = mem.data_ready;
            resp_data_s  = mem.data_rdata;
        end
    end

    // Next-state, shared wait counter and serializer load decode
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        ser_load_s  = 1'b0;
        ser_data_s  = {SHIFT_W{1'b0}};
        ser_count_s = 3'd0;
        case (state_r)
            IDLE: begin
                if (rx_valid) begin
                    state_nxt_s = ADDR;
                    cnt_nxt_s   = {CNT_W{1'b0}};
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ADDR: begin
                if (rx_valid) begin
                    cnt_nxt_s = {CNT_W{1'b0}};
                    if (rw_flag_r) begin
                        state_nxt_s = DATA;
                    end else begin
                        state_nxt_s = HALT;
                    end
                end
`ifdef FRAME_TIMEOUT_EN
                else if (cnt_r == CNT_W'(FRAME_TIMEOUT - 1)) begin
                    state_nxt_s = IDLE;
                    cnt_nxt_s   = {CNT_W{1'b0}};
                end else begin
                    cnt_nxt_s = cnt_r + CNT_W'(1);
                end
`else
                else begin
                    state_nxt_s = ADDR;
                end
`endif
            end
            DATA: begin
                if (rx_valid) begin
                    cnt_nxt_s = {CNT_W{1'b0}};
                    if (byte_cnt_r == 2'd3) begin
                        state_nxt_s = HALT;
                    end else begin
                        state_nxt_s = DATA;
                    end
                end
`ifdef FRAME_TIMEOUT_EN
                else if (cnt_r == CNT_W'(FRAME_TIMEOUT - 1)) begin
                    state_nxt_s = IDLE;
                    cnt_nxt_s   = {CNT_W{1'b0}};
                end else begin
                    cnt_nxt_s = cnt_r + CNT_W'(1);
                end
`else
                else begin
                    state_nxt_s = DATA;
                end
`endif
            end
            HALT: begin
                if (cnt_r == CNT_W'(HALT_CYCLES - 1)) begin
                    state_nxt_s = REQ;
                    cnt_nxt_s   = {CNT_W{1'b0}};
                end else begin
                    cnt_nxt_s = cnt_r + CNT_W'(1);
                end
            end
            REQ: begin
                cnt_nxt_s = {CNT_W{1'b0}};
                if (rw_flag_r) begin
                    state_nxt_s = ACK;
                end else begin
                    state_nxt_s = WAIT;
                end
            end
            WAIT: begin
                if (resp_ready_s) begin
                    ser_load_s  = 1'b1;
                    ser_data_s  = {{(SHIFT_W - RESP_W){1'b0}}, resp_data_s};
                    ser_count_s = 3'd6;
                    state_nxt_s = TX;
                end else if (cnt_r == CNT_W'(RESP_TIMEOUT - 1)) begin
                    ser_load_s  = 1'b1;
                    ser_data_s  = {NACK_BYTE, {(SHIFT_W - 8){1'b0}}};
                    ser_count_s = 3'd1;
                    state_nxt_s = TX;
                end else begin
                    cnt_nxt_s = cnt_r + CNT_W'(1);
                end
            end
            ACK: begin
                ser_load_s  = 1'b1;
                ser_data_s  = {ACK_BYTE, {(SHIFT_W - 8){1'b0}}};
                ser_count_s = 3'd1;
                state_nxt_s = TX;
            end
            TX: begin
                if (ser_done_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = TX;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State register and state-derived outputs, registered from the next state
    // so each output lines up with the state it belongs to
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r         <= IDLE;
            cnt_r           <= {CNT_W{1'b0}};
            cpu_enable_r    <= 1'b1;
            busy_r          <= 1'b0;
            write_mem_req_r <= 1'b0;
        end else begin
            state_r         <= state_nxt_s;
            cnt_r           <= cnt_nxt_s;
            cpu_enable_r    <= !rx_locked(state_nxt_s);
            busy_r          <= (state_nxt_s != IDLE);
            write_mem_req_r <= (state_nxt_s == REQ);
        end
    end

    // Frame capture; target fields only change before HALT so they are
    // stable for the whole access
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            target_mem_type_r <= 1'b0;
            rw_flag_r         <= 1'b0;
            target_addr_r     <= 9'd0;
            wdata_r           <= 32'd0;
            byte_cnt_r        <= 2'd0;
            rx_overrun_r      <= 1'b0;
        end else begin
            if (rx_valid && (state_r == IDLE)) begin
                rw_flag_r         <= rx_data[CMD_RW_BIT];
                target_mem_type_r <= rx_data[CMD_MEM_BIT];
                target_addr_r[8]  <= rx_data[CMD_ADDR8_BIT];
            end
            if (rx_valid && (state_r == ADDR)) begin
                target_addr_r[7:0] <= rx_data;
                byte_cnt_r         <= 2'd0;
            end
            if (rx_valid && (state_r == DATA)) begin
                wdata_r    <= {wdata_r[23:0], rx_data};
                byte_cnt_r <= byte_cnt_r + 2'd1;
            end
            if (rx_valid && rx_locked(state_r)) begin
                rx_overrun_r <= 1'b1;
            end
        end
    end

    uart_tx_serializer u_tx_serializer (
        .clk        (clk),
        .reset      (reset),
        .load       (ser_load_s),
        .load_data  (ser_data_s),
        .load_count (ser_count_s),
        .tx_ready   (tx_ready),
        .tx_valid   (tx_valid),
        .tx_data    (tx_data),
        .done       (ser_done_s)
    );

    assign cpu_enable          = cpu_enable_r;
    assign busy                = busy_r;
    assign rx_overrun          = rx_overrun_r;
    assign mem.write_mem_req   = write_mem_req_r;
    assign mem.target_mem_type = target_mem_type_r;
    assign mem.target_addr     = target_addr_r;
    assign mem.rw_flag         = rw_flag_r;
    assign mem.wdata           = wdata_r;

endmodule

// File: tb/tb_uart_mem_access_ctrl.sv
// Directed self-checking bench for uart_mem_access_ctrl.
// A small memory model answers reads one cycle after the request; a monitor
// records request pulses, accepted tx bytes and cpu_enable low cycles.
module tb_uart_mem_access_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;
    logic       cpu_enable;
    logic       rx_overrun;
    logic       busy;

    uart_mem_access_ctrl_if mem_bus ();

    uart_mem_access_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .tx_valid   (tx_valid),
        .tx_data    (tx_data),
        .tx_ready   (tx_ready),
        .cpu_enable (cpu_enable),
        .rx_overrun (rx_overrun),
        .busy       (busy),
        .mem        (mem_bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // 0: memory silent, 1: addressed memory answers, 2: the other memory answers
    int resp_mode = 0;
    localparam logic [41:0] RESP_WORD = {1'b1, 9'h110, 32'h12345678};

    // Monitor state
    int         cyc = 0, req_cnt = 0, low_cnt = 0, low_at_req = 0, req_cyc = 0, rise_cyc = 0;
    logic       cap_mem = 1'b0, cap_rw = 1'b0, tx_valid_d = 1'b0;
    logic [8:0] cap_addr = 9'd0;
    logic [31:0] cap_wdata = 32'd0;
    logic [7:0] tx_q[$];

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
        end
    endtask

    // Monitor, sampled on the falling edge away from the active edge
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (mem_bus.write_mem_req) begin
            req_cnt    = req_cnt + 1;
            req_cyc    = cyc;
            low_at_req = low_cnt;
            cap_mem    = mem_bus.target_mem_type;
            cap_rw     = mem_bus.rw_flag;
            cap_addr   = mem_bus.target_addr;
            cap_wdata  = mem_bus.wdata;
        end
        if (!cpu_enable) low_cnt = low_cnt + 1;
        if (tx_valid && tx_ready) tx_q.push_back(tx_data);
        if (tx_valid && !tx_valid_d) rise_cyc = cyc;
        tx_valid_d = tx_valid;
    end

    // Memory model: a read request is answered one cycle later
    initial begin
        logic sel;
        mem_bus.instr_ready = 1'b0;
        mem_bus.data_ready  = 1'b0;
        mem_bus.instr_rdata = 42'd0;
        mem_bus.data_rdata  = 42'd0;
        forever begin
            @(negedge clk);
            if (mem_bus.write_mem_req && !mem_bus.rw_flag && resp_mode != 0) begin
                sel = (resp_mode == 1) ? mem_bus.target_mem_type : !mem_bus.target_mem_type;
                @(posedge clk); #1;
                if (sel) begin
                    mem_bus.instr_rdata = RESP_WORD;
                    mem_bus.instr_ready = 1'b1;
                end else begin
                    mem_bus.data_rdata = RESP_WORD;
                    mem_bus.data_ready = 1'b1;
                end
                @(posedge clk); #1;
                mem_bus.instr_ready = 1'b0;
                mem_bus.data_ready  = 1'b0;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        rx_valid = 1'b1;
        rx_data  = b;
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int max_cyc);
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (!busy) break;
        end
        check_eq(tag, 64'(busy), 64'd0);
    endtask

    // Compare the n bytes accepted since base against exp (first byte highest)
    task automatic check_tx(input string tag, input int base, input int n, input logic [47:0] exp);
        check_eq({tag, "_n"}, 64'(tx_q.size() - base), 64'(n));
        for (int i = 0; i < n; i++) begin
            logic [7:0] a;
            a = (base + i < tx_q.size()) ? tx_q[base + i] : 8'hxx;
            check_eq(tag, 64'(a), 64'(exp[8*(n-1-i) +: 8]));
        end
    endtask

    initial begin
        int req_b, tx_b, low_b, stab_err;
        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        tx_ready = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("rst_cpu_en", 64'(cpu_enable), 64'd1);
        check_eq("rst_busy",   64'(busy), 64'd0);
        check_eq("rst_tx",     64'({tx_valid, tx_data}), 64'd0);
        check_eq("rst_req",    64'(mem_bus.write_mem_req), 64'd0);
        check_eq("rst_target", 64'({mem_bus.target_mem_type, mem_bus.target_addr, mem_bus.rw_flag}), 64'd0);
        check_eq("rst_wdata",  64'(mem_bus.wdata), 64'd0);
        check_eq("rst_ovr",    64'(rx_overrun), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Write to instruction memory address 5
        req_b = req_cnt; tx_b = tx_q.size(); low_b = low_cnt;
        send_byte(8'hC0); send_byte(8'h05);
        send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
        wait_idle("wr_idle", 200);
        check_eq("wr_req_cnt", 64'(req_cnt - req_b), 64'd1);
        check_eq("wr_halt_len", 64'(low_at_req - low_b), 64'd4);
        check_eq("wr_fields", 64'({cap_rw, cap_mem, cap_addr}), 64'({1'b1, 1'b1, 9'd5}));
        check_eq("wr_wdata", 64'(cap_wdata), 64'h0000_0000_DEAD_BEEF);
        check_tx("wr_tx", tx_b, 1, 48'hAC);
        check_eq("wr_cpu_en", 64'(cpu_enable), 64'd1);

        // Read from instruction memory address 0x110, answered at REQ+1
        resp_mode = 1;
        req_b = req_cnt; tx_b = tx_q.size();
        send_byte(8'h41); send_byte(8'h10);
        wait_idle("rd_idle", 200);
        check_eq("rd_req_cnt", 64'(req_cnt - req_b), 64'd1);
        check_eq("rd_fields", 64'({cap_rw, cap_mem, cap_addr}), 64'({1'b0, 1'b1, 9'h110}));
        check_eq("rd_latency", 64'(rise_cyc - req_cyc), 64'd2);
        check_tx("rd_tx", tx_b, 6, 48'h0310_1234_5678);

        // Read from data memory address 3; only the instruction ready pulses
        resp_mode = 2;
        tx_b = tx_q.size();
        send_byte(8'h00); send_byte(8'h03);
        wait_idle("to_idle", 200);
        check_eq("to_fields", 64'({cap_rw, cap_mem, cap_addr}), 64'({1'b0, 1'b0, 9'h003}));
        check_eq("to_wait_len", 64'(rise_cyc - req_cyc), 64'd17);
        check_tx("to_tx", tx_b, 1, 48'hEE);
        check_eq("to_cpu_en", 64'(cpu_enable), 64'd1);

        // Data memory read with 20 cycles of transmitter backpressure
        resp_mode = 1;
        tx_ready  = 1'b0;
        tx_b = tx_q.size();
        send_byte(8'h01); send_byte(8'h10);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (tx_valid) break;
        end
        check_eq("bp_valid", 64'(tx_valid), 64'd1);
        stab_err = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (tx_data !== 8'h03 || tx_valid !== 1'b1) stab_err++;
        end
        check_eq("bp_stable", 64'(stab_err), 64'd0);
        check_eq("bp_cpu_low", 64'(cpu_enable), 64'd0);
        @(posedge clk); #1;
        tx_ready = 1'b1;
        wait_idle("bp_idle", 200);
        check_tx("bp_tx", tx_b, 6, 48'h0310_1234_5678);

        // Overrun: a byte arrives during HALT of a data-memory write
        check_eq("ovr_before", 64'(rx_overrun), 64'd0);
        req_b = req_cnt; tx_b = tx_q.size();
        send_byte(8'h80); send_byte(8'h07);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        send_byte(8'h55);
        wait_idle("ovr_idle", 200);
        check_eq("ovr_flag", 64'(rx_overrun), 64'd1);
        check_eq("ovr_req_cnt", 64'(req_cnt - req_b), 64'd1);
        check_eq("ovr_fields", 64'({cap_rw, cap_mem, cap_addr}), 64'({1'b1, 1'b0, 9'd7}));
        check_eq("ovr_wdata", 64'(cap_wdata), 64'h0000_0000_1122_3344);
        check_tx("ovr_tx", tx_b, 1, 48'hAC);
        check_eq("ovr_busy", 64'(busy), 64'd0);

        // Reset in DATA after two data bytes, then a complete frame
        req_b = req_cnt; tx_b = tx_q.size();
        send_byte(8'h80); send_byte(8'h09); send_byte(8'hAA); send_byte(8'hBB);
        reset = 1'b1;
        @(negedge clk);
        check_eq("mrst_busy", 64'(busy), 64'd0);
        check_eq("mrst_cpu_en", 64'(cpu_enable), 64'd1);
        check_eq("mrst_ovr", 64'(rx_overrun), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (10) @(negedge clk);
        check_eq("mrst_no_req", 64'(req_cnt - req_b), 64'd0);
        send_byte(8'hC1); send_byte(8'hFF);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
        wait_idle("mrst_idle", 200);
        check_eq("mrst_req_cnt", 64'(req_cnt - req_b), 64'd1);
        check_eq("mrst_fields", 64'({cap_rw, cap_mem, cap_addr}), 64'({1'b1, 1'b1, 9'h1FF}));
        check_eq("mrst_wdata", 64'(cap_wdata), 64'h0000_0000_0102_0304);
        check_tx("mrst_tx", tx_b, 1, 48'hAC);

        // A partial frame waits; completing it later still executes the read
        req_b = req_cnt; tx_b = tx_q.size();
        send_byte(8'h00);
        repeat (50) @(negedge clk);
        check_eq("part_busy", 64'(busy), 64'd1);
        check_eq("part_no_req", 64'(req_cnt - req_b), 64'd0);
        send_byte(8'h02);
        wait_idle("part_idle", 200);
        check_eq("part_addr", 64'(cap_addr), 64'h2);
        check_tx("part_tx", tx_b, 6, 48'h0310_1234_5678);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog act=running exp=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
